spi_xfer_ctrl: RTL

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sclk_div.sv | 54 +++++
 rtl/spi_xfer_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller: state encoding,
// default parameter values and the edge-counter width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        XFER    = 3'd2,
        HOLD    = 3'd3,
        CS_WAIT = 3'd4
    } spi_state_t;

    localparam int unsigned SPI_DEF_DIVIDER_WIDTH = 8;
    localparam int unsigned SPI_DEF_DATA_WIDTH    = 8;

    // Bits needed to count 0 .. 2*data_width SCLK edges.
    function automatic int unsigned edge_cnt_width(input int unsigned data_width);
        return $clog2(2 * data_width + 1);
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period generator. The counter runs while run_i is high and
// produces a half_tick every div_i+1 cycles; when toggle_i is also high
// the tick flips sclk and is classified as a lead edge (leaving the idle
// level) or a trail edge (returning to it).
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int unsigned C_DIVIDER_WIDTH = SPI_DEF_DIVIDER_WIDTH
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       run_i,
    input  logic [C_DIVIDER_WIDTH-1:0] div_i,
    input  logic                       toggle_i,
    input  logic                       cpol_i,
    input  logic                       load_i,
    input  logic                       load_val_i,
    output logic                       half_tick_o,
    output logic                       lead_edge_o,
    output logic                       trail_edge_o,
    output logic                       sclk_o
);

    logic [C_DIVIDER_WIDTH-1:0] cnt_q;
    logic                       sclk_q;

    assign half_tick_o  = run_i && (cnt_q == div_i);
    assign lead_edge_o  = half_tick_o && toggle_i && (sclk_q == cpol_i);
    assign trail_edge_o = half_tick_o && toggle_i && (sclk_q != cpol_i);
    assign sclk_o       = sclk_q;

    // Half-period counter: restarts on every tick and whenever idle.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run_i || half_tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // SCLK level: forced to the idle level on load, else toggled on ticks.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
        end else if (load_i) begin
            sclk_q <= load_val_i;
        end else if (half_tick_o && toggle_i) begin
            sclk_q <= ~sclk_q;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame controller. Frames pass IDLE -> SETUP -> XFER -> HOLD,
// then end in IDLE (CS released) or CS_WAIT (CS kept low, next frame skips
// SETUP). Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input.
// Handshake: start is sampled only while busy=0 and enable=1; busy rises
// the cycle after acceptance and falls together with the one-cycle done pulse.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned C_DIVIDER_WIDTH = SPI_DEF_DIVIDER_WIDTH,
    parameter int unsigned C_DATA_WIDTH    = SPI_DEF_DATA_WIDTH
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       CPOL,
    input  logic                       CPHA,
    input  logic [C_DIVIDER_WIDTH-1:0] divider_i,
    input  logic                       start,
    input  logic                       tx_last,
    input  logic [C_DATA_WIDTH-1:0]    tx_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic                       lsb_first,
`endif
    input  logic                       miso,
    output logic                       busy,
    output logic                       done,
    output logic                       rx_valid,
    output logic [C_DATA_WIDTH-1:0]    rx_data,
    output logic                       sclk,
    output logic                       mosi,
    output logic                       cs_n,
    output spi_state_t                 dbg_state_o
);

    localparam int unsigned EW = edge_cnt_width(C_DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * C_DATA_WIDTH - 1);

    spi_state_t                 state_q, state_d;
    logic [C_DATA_WIDTH-1:0]    tx_sh_q, rx_sh_q, rx_data_q;
    logic [EW-1:0]              edge_cnt_q;
    logic [C_DIVIDER_WIDTH-1:0] div_q;
    logic                       cpol_q, cpha_q, last_q;
    logic                       cs_n_q, busy_q, done_q, rx_valid_q;
    logic                       accept, finish, lsb_sel;
    logic                       half_tick, lead_edge, trail_edge;
    logic                       final_edge, first_edge, do_shift, do_sample;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q;
    // Bit order is captured with the other frame settings.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else if (accept) begin
            lsb_q <= lsb_first;
        end
    end
    assign lsb_sel = lsb_q;
`else
    assign lsb_sel = 1'b0;
`endif

    spi_sclk_div #(.C_DIVIDER_WIDTH(C_DIVIDER_WIDTH)) u_div (
        .sysclk      (sysclk),
        .rst         (rst),
        .run_i       ((state_q == SETUP) || (state_q == XFER) || (state_q == HOLD)),
        .div_i       (div_q),
        .toggle_i    (state_q == XFER),
        .cpol_i      (cpol_q),
        .load_i      (!enable || (state_q == IDLE) || accept),
        .load_val_i  (CPOL),
        .half_tick_o (half_tick),
        .lead_edge_o (lead_edge),
        .trail_edge_o(trail_edge),
        .sclk_o      (sclk)
    );

    // Odd edges are lead edges and even edges are trail edges; edge 1 only
    // presents the preloaded MSB and the final edge never shifts.
    assign final_edge = (edge_cnt_q == LAST_EDGE);
    assign first_edge = (edge_cnt_q == '0);
    assign do_shift   = cpha_q ? (lead_edge && !first_edge) : (trail_edge && !final_edge);
    assign do_sample  = cpha_q ? trail_edge : lead_edge;

    // State register.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus frame accept/finish strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) begin accept = 1'b1; state_d = SETUP; end
                CS_WAIT: if (start) begin accept = 1'b1; state_d = XFER; end
                SETUP:   if (half_tick) state_d = XFER;
                XFER:    if (half_tick && final_edge) state_d = HOLD;
                HOLD: begin
                    if (half_tick) begin
                        finish  = 1'b1;
                        state_d = last_q ? IDLE : CS_WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame datapath: settings latch, shift registers, edge count, status.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            edge_cnt_q <= '0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            last_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            done_q     <= finish;
            rx_valid_q <= finish;
            if (accept) begin
                tx_sh_q    <= tx_data;
                rx_sh_q    <= '0;
                edge_cnt_q <= '0;
                div_q      <= divider_i;
                cpol_q     <= CPOL;
                cpha_q     <= CPHA;
                last_q     <= tx_last;
            end else begin
                if (lead_edge || trail_edge) edge_cnt_q <= edge_cnt_q + 1'b1;
                if (do_shift) begin
                    tx_sh_q <= lsb_sel ? {1'b0, tx_sh_q[C_DATA_WIDTH-1:1]}
                                       : {tx_sh_q[C_DATA_WIDTH-2:0], 1'b0};
                end
                if (do_sample) begin
                    rx_sh_q <= lsb_sel ? {miso, rx_sh_q[C_DATA_WIDTH-1:1]}
                                       : {rx_sh_q[C_DATA_WIDTH-2:0], miso};
                end
            end
            if (finish) rx_data_q <= rx_sh_q;
            if (!enable) begin
                cs_n_q <= 1'b1;
                busy_q <= 1'b0;
            end else if (accept) begin
                cs_n_q <= 1'b0;
                busy_q <= 1'b1;
            end else if (finish) begin
                cs_n_q <= last_q;
                busy_q <= 1'b0;
            end
        end
    end

    assign mosi        = lsb_sel ? tx_sh_q[0] : tx_sh_q[C_DATA_WIDTH-1];
    assign cs_n        = cs_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign dbg_state_o = state_q;

endmodule
